// File: rtl/serial_dot_mac.sv
// Serial dot-product unit: one (x, h) pair per accepted handshake, a single
// multiplier feeding a wrapping accumulator, result held until downstream takes it.
module serial_dot_mac #(
    parameter int N_TAPS = 10,
    parameter int DW     = 4,
    parameter int OW     = 12,
    parameter int CW     = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] x_i,
    input  logic [DW-1:0] h_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [OW-1:0] out_o,
    output logic [CW-1:0] tap_idx_o
);

    localparam logic          ST_ACC   = 1'b0;
    localparam logic          ST_HOLD  = 1'b1;
    localparam logic [CW-1:0] LAST_TAP = CW'(N_TAPS - 1);

    // Product is zero-extended (or truncated) to OW; the add wraps modulo 2^OW.
    function automatic logic [OW-1:0] mac_wrap(input logic [OW-1:0] acc,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [2*DW-1:0] prod;
        prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        return acc + OW'(prod);
    endfunction

    logic          state_q, state_d;
    logic [OW-1:0] acc_q, acc_d;
    logic [OW-1:0] out_q, out_d;
    logic [CW-1:0] tap_q, tap_d;
    logic [OW-1:0] sum;
    logic          accept;

    assign in_ready_o  = (state_q == ST_ACC);
    assign out_valid_o = (state_q == ST_HOLD);
    assign out_o       = out_q;
    assign tap_idx_o   = tap_q;

    // clear wins over both handshakes, so a pair offered alongside it is dropped.
    assign accept = in_valid_i & in_ready_o & ~clear_i;
    assign sum    = mac_wrap(acc_q, x_i, h_i);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        out_d   = out_q;
        tap_d   = tap_q;
        if (state_q == ST_ACC) begin
            if (clear_i) begin
                acc_d = '0;
                tap_d = '0;
            end else if (accept) begin
                if (tap_q == LAST_TAP) begin
                    out_d   = sum;
                    acc_d   = '0;
                    tap_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    acc_d = sum;
                    tap_d = tap_q + 1'b1;
                end
            end
        end else if (clear_i || out_ready_i) begin
            state_d = ST_ACC;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            out_q   <= '0;
            tap_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            tap_q   <= tap_d;
        end
    end

endmodule

// File: tb/tb_serial_dot_mac.sv
// Directed + randomized bench for serial_dot_mac; a second instance with OW=11
// shares all inputs to exercise the modulo-2^OW wrap.
module tb_serial_dot_mac;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        rst_n, clear, in_valid, out_ready;
    logic [3:0]  x, h;
    logic        in_ready, out_valid, in_ready_b, out_valid_b;
    logic [11:0] out;
    logic [10:0] out_b;
    logic [3:0]  tap, tap_b;

    int checks   = 0;
    int failures = 0;
    int q[$];
    int m_acc, m_tap, m_out;
    bit m_hold, prev_valid;

    always #5 clk = ~clk;

    serial_dot_mac #(.N_TAPS(10), .DW(4), .OW(12), .CW(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .x_i(x), .h_i(h), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_o(out), .tap_idx_o(tap)
    );

    serial_dot_mac #(.N_TAPS(10), .DW(4), .OW(11), .CW(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid),
        .in_ready_o(in_ready_b), .x_i(x), .h_i(h), .out_valid_o(out_valid_b),
        .out_ready_i(out_ready), .out_o(out_b), .tap_idx_o(tap_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: advance the reference model with the inputs as driven, then compare.
    task automatic cycle();
        bit acc_ev;
        int exp;
        acc_ev = !m_hold && in_valid && !clear;
        @(posedge clk);
        #1;
        if (m_hold) begin
            if (clear || out_ready) m_hold = 1'b0;
        end else if (clear) begin
            m_acc = 0;
            m_tap = 0;
        end else if (acc_ev) begin
            m_acc += int'(x) * int'(h);
            m_tap++;
            if (m_tap == N) begin
                q.push_back(m_acc);
                m_acc  = 0;
                m_tap  = 0;
                m_hold = 1'b1;
            end
        end
        chk("in_ready", in_ready, !m_hold);
        chk("out_valid", out_valid, m_hold);
        chk("tap_idx", tap, m_tap);
        chk("out_valid_b", out_valid_b, m_hold);
        chk("tap_idx_b", tap_b, m_tap);
        if (out_valid === 1'b1 && !prev_valid) begin
            chk("sb_nonempty", q.size() > 0, 1);
            if (q.size() > 0) begin
                exp   = q.pop_front();
                m_out = exp;
            end
        end
        chk("out", out, m_out % 4096);
        chk("out_ow11", out_b, m_out % 2048);
        prev_valid = (out_valid === 1'b1);
    endtask

    task automatic pair(input int xv, input int hv);
        in_valid = 1'b1;
        x        = 4'(xv);
        h        = 4'(hv);
        cycle();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        clear    = 1'b0;
        rst_n    = 1'b0;
        #3;
        m_acc = 0; m_tap = 0; m_out = 0; m_hold = 1'b0; prev_valid = 1'b0;
        q.delete();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_tap", tap, 0);
        chk("rst_out", out, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int frames, hold_cnt;
        bit was_hold;
        rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; h = '0;
        m_acc = 0; m_tap = 0; m_out = 0; m_hold = 1'b0; prev_valid = 1'b0;
        #2;

        // 1: reset state
        do_reset();
        idle();
        chk("t1_in_ready", in_ready, 1);

        // 2: ramp frame back-to-back, out_ready high; next frame starts after one HOLD cycle
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) pair(i + 1, 1);
        chk("t2_out", out, 55);
        chk("t2_valid", out_valid, 1);
        pair(1, 1);
        chk("t2_valid_drop", out_valid, 0);
        pair(1, 1);
        chk("t2_next_tap", tap, 1);
        for (int i = 0; i < N - 1; i++) pair(1, 1);
        chk("t2_second", out, 10);
        idle();

        // 3: maximum operands, exact at OW=12 and wrapped at OW=11
        for (int i = 0; i < N; i++) pair(15, 15);
        chk("t3_out", out, 2250);
        chk("t3_out11", out_b, 202);
        idle();

        // 4: random gaps, out_ready withheld for 5 HOLD cycles
        frames = 0; hold_cnt = 0;
        for (int cyc = 0; cyc < 400 && frames < 3; cyc++) begin
            hold_cnt  = m_hold ? hold_cnt + 1 : 0;
            out_ready = m_hold && (hold_cnt > 5);
            in_valid  = 1'($urandom_range(0, 1));
            x         = 4'($urandom_range(0, 15));
            h         = 4'($urandom_range(0, 15));
            was_hold  = m_hold;
            cycle();
            if (was_hold && !m_hold) frames++;
        end
        chk("t4_frames", frames, 3);

        // 5: clear after 4 pairs, with a pair offered alongside clear
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) pair(7, 9);
        clear = 1'b1;
        pair(9, 9);
        clear = 1'b0;
        chk("t5_tap_cleared", tap, 0);
        for (int i = 0; i < N; i++) pair(2, 3);
        chk("t5_out", out, 60);

        // clear while in HOLD drops the result and returns to ACC
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) pair(1, 2);
        chk("t5b_hold", out_valid, 1);
        clear = 1'b1;
        idle();
        clear = 1'b0;
        chk("t5b_cleared", out_valid, 0);
        out_ready = 1'b1;

        // 6: async reset after 7 pairs, then a fresh frame
        for (int i = 0; i < 7; i++) pair(5, 5);
        do_reset();
        idle();
        for (int i = 0; i < N; i++) pair(1, 1);
        chk("t6_out", out, 10);
        idle();
        idle();
        chk("sb_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
